clken_nco_gen: RTL and testbench
================================

Name: clken_nco_gen

Overview:
- Multi-channel fractional clock-enable generator.
- Runs on the fast system clock from the core PLL (e.g. 114.545456 MHz).
- Derives N independent, runtime-programmable enable strobes (CPU 1.79 MHz, ANTIC/GTIA, POKEY, audio) using phase accumulators. No extra PLL outputs are needed.
- Gates all strobes on PLL lock plus a settle interval, so downstream logic never sees enables from an unstable clock.

Parameters:
- NUM_CH, 4, number of enable channels.
- ACC_W, 24, accumulator width in bits; f_ce = f_clk * inc / 2^ACC_W.
- SETTLE_CYC, 1024, clk cycles of stable lock required before strobes start.
- INC_DEFAULT, 262144, per-channel increment loaded at reset (f_clk/64).

Ports:
- clk  input  1  system clock, all logic in this domain.
- reset_n  input  1  asynchronous, active-low reset.
- pll_locked  input  1  PLL lock, asynchronous to clk; synchronised internally.
- inc_i  input  NUM_CH*ACC_W  new increments; channel k at bits [k*ACC_W +: ACC_W].
- inc_valid  input  1  request to load inc_i.
- inc_ready  output  1  high when a new load is accepted.
- ch_run  input  NUM_CH  per-channel run; low holds that accumulator at 0.
- ce_o  output  NUM_CH  single-cycle enable strobes.
- ready_o  output  1  high while in RUN.

Behaviour:
- Reset values:
  - ce_o=0, ready_o=0, inc_ready=0, accumulators=0.
  - Active increments = INC_DEFAULT.
  - No pending increments; state=WAIT_LOCK.
- Lock sync: pll_locked passes through a 2-flop synchroniser (lock_s). Two cycles of latency are added to all lock decisions.
- FSM:
  - WAIT_LOCK: lock_s=1 -> SETTLE, settle counter cleared.
  - SETTLE: counter increments each cycle. lock_s=0 -> WAIT_LOCK. Counter==SETTLE_CYC-1 -> RUN.
  - RUN: ready_o=1. lock_s=0 -> WAIT_LOCK.
  - On leaving RUN: same cycle clears all accumulators. ce_o=0 from next cycle. Pending loads are discarded.
- Accumulator per channel, RUN and ch_run[k]=1:
  - {carry,acc} = acc + inc_act, computed at ACC_W+1 bits.
  - acc keeps the low ACC_W bits.
  - ce_o[k] is the registered carry, one cycle after the add. It is never high two cycles in a row unless inc_act >= 2^(ACC_W-1).
- Channel off: ch_run[k]=0 or state != RUN gives acc=0, ce_o[k]=0.
- Re-enable: after ch_run rises, the first strobe appears after ceil(2^ACC_W/inc) adds.
- inc_act=0: channel never strobes.
- inc_act=2^ACC_W-1: strobes every cycle except one per 2^ACC_W.
- Increment load handshake:
  - inc_ready = (state==RUN) && no channel pending.
  - On inc_valid && inc_ready, inc_i is captured into pending registers and a pend flag is set for every channel.
  - A channel copies pending to inc_act on the cycle its carry is generated, or immediately if ch_run[k]=0. It then clears its pend flag.
  - This preserves phase continuity: no short or long period at the switch.
  - inc_ready returns high the cycle after the last pend flag clears.
  - inc_valid while inc_ready=0 is ignored, with no queueing.
  - A channel with inc_act=0 and pend set loads immediately.
- Simultaneous events:
  - Lock loss on the same cycle as a load: the lock loss wins and pending is discarded.
  - ch_run fall on the same cycle as a carry: no strobe is emitted.
- Mid-operation reset_n assertion forces the reset values asynchronously.

Optional Feature:
- Macro: CLKEN_SQUARE_EN.
- Defined:
  - Adds output sq_o [NUM_CH].
  - Each bit toggles on every ce_o[k] strobe, giving f_ce/2 at roughly 50% duty (pixel-clock or external audio use).
  - Reset 0. Cleared whenever the channel is off.
- Not defined: port absent, no extra flops.

Decomposition:
- Package clken_pkg holds:
  - ACC_W default and INC_DEFAULT.
  - FSM state enum {WAIT_LOCK, SETTLE, RUN}.
  - Helper function inc_for(f_clk_hz, f_ce_hz) returning ACC_W-bit round(f_ce*2^ACC_W/f_clk), for testbench and top-level constants.
- One sub-module, clken_nco_ch: a single accumulator with pending-increment logic and the optional toggle. It is instantiated NUM_CH times via generate. The FSM and handshake stay in the parent.

Test Plan:
- Lock gating: hold pll_locked=0 for 500 cycles, then raise it -> ce_o=0 throughout; ready_o rises exactly SETTLE_CYC+2 (±1 for sync) cycles after the pll_locked edge.
- Exact divide: ACC_W=24, inc=262144 on channel 0 -> ce_o[0] pulses every 64 cycles, 1000 periods with zero jitter.
- Fractional rate: inc=inc_for(114545456,1789773)=262144±1 and inc=1000003 -> mean period over 2^16 strobes within 1 ppm of 2^24/inc; adjacent periods differ by at most 1 cycle.
- Glitch-free reload: change inc from 262144 to 524288 mid-period -> old 64-cycle period completes, then 32-cycle periods; inc_ready low until the switch; a second inc_valid during pending is ignored.
- Lock loss: drop pll_locked in RUN -> within 3 cycles ready_o=0, ce_o=0, accumulators 0; relock -> full SETTLE repeated, then periods identical to the first run.
- Async reset mid-RUN with CLKEN_SQUARE_EN -> all outputs 0 immediately; after release, sq_o[k] toggles once per ce_o[k] strobe.

Source files
------------

// File: rtl/clken_pkg.sv
// clken_pkg: shared constants, FSM states and rate helper
// for the clken_nco_gen fractional clock-enable generator.
package clken_pkg;

  localparam int CLKEN_ACC_W = 24;
  localparam logic [CLKEN_ACC_W-1:0] CLKEN_INC_DEFAULT = 24'd262144;

  typedef enum logic [1:0] {
    WAIT_LOCK,
    SETTLE,
    RUN
  } state_t;

  // round(f_ce * 2^ACC_W / f_clk)
  function automatic logic [CLKEN_ACC_W-1:0] inc_for(
    input longint unsigned f_clk_hz,
    input longint unsigned f_ce_hz
  );
    longint unsigned num;
    num = (f_ce_hz << CLKEN_ACC_W) + (f_clk_hz >> 1);
    return CLKEN_ACC_W'(num / f_clk_hz);
  endfunction

endpackage

// File: rtl/clken_nco_ch.sv
// clken_nco_ch: one phase-accumulator channel with a pending
// increment swapped in on carry. Optional toggle: CLKEN_SQUARE_EN.
module clken_nco_ch
  import clken_pkg::*;
#(
  parameter int ACC_W = CLKEN_ACC_W,
  parameter logic [ACC_W-1:0] INC_DEFAULT =
    ACC_W'(CLKEN_INC_DEFAULT)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             run,
  input  logic             ch_run,
  input  logic             load,
  input  logic [ACC_W-1:0] inc_new,
  output logic             pend,
  output logic             ce
`ifdef CLKEN_SQUARE_EN
  ,
  output logic             sq
`endif
);

  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] inc_act;
  logic [ACC_W-1:0] inc_pend;
  logic [ACC_W:0]   sum;
  logic             carry;
  logic             active;
  logic             swap;

  assign sum    = {1'b0, acc} + {1'b0, inc_act};
  assign carry  = sum[ACC_W];
  assign active = run && ch_run;
  // switching on the carry keeps the phase continuous
  assign swap   = pend && (!ch_run || carry || inc_act == '0);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      acc <= '0;
      ce  <= 1'b0;
    end else if (active) begin
      acc <= sum[ACC_W-1:0];
      ce  <= carry;
    end else begin
      acc <= '0;
      ce  <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pend     <= 1'b0;
      inc_pend <= '0;
      inc_act  <= INC_DEFAULT;
    end else if (!run) begin
      pend <= 1'b0;
    end else if (load) begin
      pend     <= 1'b1;
      inc_pend <= inc_new;
    end else if (swap) begin
      pend    <= 1'b0;
      inc_act <= inc_pend;
    end
  end

`ifdef CLKEN_SQUARE_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sq <= 1'b0;
    end else if (!active) begin
      sq <= 1'b0;
    end else if (carry) begin
      sq <= ~sq;
    end
  end
`endif

endmodule

// File: rtl/clken_nco_gen.sv
// clken_nco_gen: lock-gated multi-channel fractional clock enables.
// Define CLKEN_SQUARE_EN to add the sq_o half-rate square outputs.
module clken_nco_gen
  import clken_pkg::*;
#(
  parameter int NUM_CH     = 4,
  parameter int ACC_W      = CLKEN_ACC_W,
  parameter int SETTLE_CYC = 1024,
  parameter logic [ACC_W-1:0] INC_DEFAULT =
    ACC_W'(CLKEN_INC_DEFAULT)
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    pll_locked,
  input  logic [NUM_CH*ACC_W-1:0] inc_i,
  input  logic                    inc_valid,
  output logic                    inc_ready,
  input  logic [NUM_CH-1:0]       ch_run,
  output logic [NUM_CH-1:0]       ce_o,
  output logic                    ready_o
`ifdef CLKEN_SQUARE_EN
  ,
  output logic [NUM_CH-1:0]       sq_o
`endif
);

  localparam int CNT_W = $clog2(SETTLE_CYC) + 1;

  state_t           state;
  state_t           state_nx;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nx;
  logic             lock_m;
  logic             lock_s;
  logic             run_ok;
  logic             load;
  logic [NUM_CH-1:0] pend;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      lock_m <= 1'b0;
      lock_s <= 1'b0;
    end else begin
      lock_m <= pll_locked;
      lock_s <= lock_m;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= WAIT_LOCK;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    unique case (state)
      WAIT_LOCK: begin
        cnt_nx = '0;
        if (lock_s) state_nx = SETTLE;
      end
      SETTLE: begin
        cnt_nx = cnt + CNT_W'(1);
        if (!lock_s) state_nx = WAIT_LOCK;
        else if (cnt == CNT_W'(SETTLE_CYC - 1)) state_nx = RUN;
      end
      RUN: begin
        if (!lock_s) state_nx = WAIT_LOCK;
      end
      default: state_nx = WAIT_LOCK;
    endcase
  end

  // leaving RUN clears channels in the same cycle the loss is seen
  assign ready_o   = (state == RUN);
  assign run_ok    = ready_o && lock_s;
  assign inc_ready = ready_o && !(|pend);
  assign load      = inc_valid && inc_ready && lock_s;

  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    clken_nco_ch #(
      .ACC_W      (ACC_W),
      .INC_DEFAULT(INC_DEFAULT)
    ) u_ch (
      .clk    (clk),
      .reset_n(reset_n),
      .run    (run_ok),
      .ch_run (ch_run[k]),
      .load   (load),
      .inc_new(inc_i[k*ACC_W +: ACC_W]),
      .pend   (pend[k]),
      .ce     (ce_o[k])
`ifdef CLKEN_SQUARE_EN
      ,
      .sq     (sq_o[k])
`endif
    );
  end

endmodule

// File: tb/tb_clken_nco_gen.sv
// tb_clken_nco_gen: expected strobe cycles and level checks are
// queued by the stimulus; a negedge monitor pops and compares them.
module tb_clken_nco_gen;
  import clken_pkg::*;

  localparam int NUM_CH     = 4;
  localparam int ACC_W      = 24;
  localparam int SETTLE_CYC = 1024;

  localparam int unsigned T_LOCK   = 500;
  localparam int unsigned T_RUN1   = T_LOCK + SETTLE_CYC + 3;
  localparam int unsigned T_LD1    = 1600;
  localparam int unsigned T_SW0    = T_RUN1 + 128;
  localparam int unsigned T_CH1    = 2000;
  localparam int unsigned T_LD2    = 3030;
  localparam int unsigned T_IGN    = 3040;
  localparam int unsigned T_SW     = T_RUN1 + 64 * 24;
  localparam int unsigned T_LOSS   = 4000;
  localparam int unsigned T_RELOCK = 4100;
  localparam int unsigned T_RUN2   = T_RELOCK + SETTLE_CYC + 3;
  localparam int unsigned T_RST    = 6000;
  localparam int unsigned T_REL    = 6010;
  localparam int unsigned T_RUN3   = T_REL + SETTLE_CYC + 3;
  localparam int unsigned T_END    = 7700;

  localparam longint unsigned INC_64 = 262144;
  localparam longint unsigned INC_32 = 524288;
  localparam longint unsigned INC_F  = 1000003;
  localparam longint unsigned INC_MX = 24'hFFFFFF;

  localparam int SEL_RDY = 0;
  localparam int SEL_IRD = 1;
  localparam int SEL_CE  = 2;

  typedef struct {
    int unsigned at;
    int          sel;
    int unsigned val;
  } lv_t;

  logic                    clk = 1'b0;
  logic                    reset_n;
  logic                    pll_locked;
  logic [NUM_CH*ACC_W-1:0] inc_i;
  logic                    inc_valid;
  logic                    inc_ready;
  logic [NUM_CH-1:0]       ch_run;
  logic [NUM_CH-1:0]       ce_o;
  logic                    ready_o;
`ifdef CLKEN_SQUARE_EN
  logic [NUM_CH-1:0]       sq_o;
`endif

  int unsigned cyc = 0;
  int          tests = 0;
  int          fails = 0;
  int unsigned q[3][$];
  lv_t         lv[$];
  lv_t         e;
  int unsigned act;
  logic [2:0]  sq_exp = '0;

  clken_nco_gen #(
    .NUM_CH     (NUM_CH),
    .ACC_W      (ACC_W),
    .SETTLE_CYC (SETTLE_CYC),
    .INC_DEFAULT(24'd262144)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .pll_locked(pll_locked),
    .inc_i     (inc_i),
    .inc_valid (inc_valid),
    .inc_ready (inc_ready),
    .ch_run    (ch_run),
    .ce_o      (ce_o),
    .ready_o   (ready_o)
`ifdef CLKEN_SQUARE_EN
    ,
    .sq_o      (sq_o)
`endif
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // strobe at base+j whenever floor(j*inc/2^24) steps
  function automatic void push_nco(
    input int k, input int unsigned base,
    input longint unsigned inc, input int unsigned upto
  );
    for (longint unsigned j = 1; base + j <= upto; j++) begin
      if (((j * inc) >> ACC_W) != (((j - 1) * inc) >> ACC_W))
        q[k].push_back(base + int'(j));
    end
  endfunction

  function automatic void add_lv(
    input int unsigned at, input int sel, input int unsigned val
  );
    lv.push_back('{at, sel, val});
  endfunction

  task automatic wait_cyc(input int unsigned t);
    while (cyc < t) @(negedge clk);
  endtask

  initial begin
    reset_n    = 1'b0;
    pll_locked = 1'b0;
    inc_i      = '0;
    inc_valid  = 1'b0;
    ch_run     = '0;
    add_lv(2, SEL_RDY, 0);
    add_lv(2, SEL_IRD, 0);
    add_lv(2, SEL_CE, 0);
    wait_cyc(4);
    reset_n = 1'b1;
    ch_run  = 4'b0001;

    wait_cyc(T_LOCK);
    pll_locked = 1'b1;
    add_lv(T_RUN1 - 1, SEL_RDY, 0);
    add_lv(T_RUN1, SEL_RDY, 1);
    add_lv(T_RUN1, SEL_IRD, 1);
    add_lv(T_LD1, SEL_IRD, 1);
    push_nco(0, T_RUN1, INC_64, T_SW);

    wait_cyc(T_LD1);
    inc_i = {24'd262144, 24'd0, 24'd1000003, 24'd262144};
    inc_valid = 1'b1;
    add_lv(T_LD1 + 1, SEL_IRD, 0);
    add_lv(T_SW0 - 1, SEL_IRD, 0);
    add_lv(T_SW0, SEL_IRD, 1);
    wait_cyc(T_LD1 + 1);
    inc_valid = 1'b0;

    wait_cyc(T_CH1);
    ch_run = 4'b0111;
    push_nco(1, T_CH1, INC_F, T_LOSS + 2);
    add_lv(T_LD2, SEL_IRD, 1);

    wait_cyc(T_LD2);
    inc_i = {24'd262144, 24'hFFFFFF, 24'd1000003, 24'd524288};
    inc_valid = 1'b1;
    push_nco(0, T_SW, INC_32, T_LOSS + 2);
    push_nco(2, T_LD2 + 2, INC_MX, T_LOSS + 2);
    add_lv(T_LD2 + 5, SEL_IRD, 0);
    add_lv(T_SW - 1, SEL_IRD, 0);
    add_lv(T_SW, SEL_IRD, 1);
    wait_cyc(T_LD2 + 1);
    inc_valid = 1'b0;

    wait_cyc(T_IGN);
    inc_i = {4{24'd1}};
    inc_valid = 1'b1;
    wait_cyc(T_IGN + 1);
    inc_valid = 1'b0;

    wait_cyc(T_LOSS);
    pll_locked = 1'b0;
    add_lv(T_LOSS + 2, SEL_RDY, 1);
    add_lv(T_LOSS + 3, SEL_RDY, 0);
    add_lv(T_LOSS + 3, SEL_CE, 0);
    add_lv(T_LOSS + 3, SEL_IRD, 0);

    wait_cyc(T_RELOCK);
    pll_locked = 1'b1;
    add_lv(T_RUN2 - 1, SEL_RDY, 0);
    add_lv(T_RUN2, SEL_RDY, 1);
    push_nco(0, T_RUN2, INC_32, T_RST);
    push_nco(1, T_RUN2, INC_F, T_RST);
    push_nco(2, T_RUN2, INC_MX, T_RST);

    wait_cyc(T_RST);
    #2 reset_n = 1'b0;

    wait_cyc(T_REL);
    reset_n = 1'b1;
    add_lv(T_RUN3 - 1, SEL_RDY, 0);
    add_lv(T_RUN3, SEL_RDY, 1);
    for (int k = 0; k < 3; k++) push_nco(k, T_RUN3, INC_64, T_END);
  end

  always @(negedge clk) begin
    if (cyc == T_LOSS + 3 || cyc == T_RST + 2) sq_exp = '0;

    for (int k = 0; k < 3; k++) begin
      while (q[k].size() > 0 && q[k][0] < cyc) begin
        tests++;
        fails++;
        $display("FAIL strobe_ch%0d: none at cycle %0d, required one",
                 k, q[k][0]);
        void'(q[k].pop_front());
      end
      if (ce_o[k]) begin
        tests++;
        if (q[k].size() > 0 && q[k][0] == cyc) begin
          void'(q[k].pop_front());
          sq_exp[k] = ~sq_exp[k];
`ifdef CLKEN_SQUARE_EN
          tests++;
          if (sq_o[k] !== sq_exp[k]) begin
            fails++;
            $display("FAIL sq_ch%0d at cycle %0d: got %0b want %0b",
                     k, cyc, sq_o[k], sq_exp[k]);
          end
`endif
        end else begin
          fails++;
          $display("FAIL strobe_ch%0d: strobe at cycle %0d, required none",
                   k, cyc);
        end
      end
    end

    if (ce_o[3]) begin
      tests++;
      fails++;
      $display("FAIL strobe_ch3: strobe at cycle %0d, required none", cyc);
    end

    while (lv.size() > 0 && lv[0].at <= cyc) begin
      e = lv.pop_front();
      if (e.sel == SEL_RDY) act = {31'd0, ready_o};
      else if (e.sel == SEL_IRD) act = {31'd0, inc_ready};
      else act = {28'd0, ce_o};
      tests++;
      if (act !== e.val) begin
        fails++;
        $display("FAIL level_sel%0d at cycle %0d: got %0d want %0d",
                 e.sel, cyc, act, e.val);
      end
    end

    if (cyc == T_END + 1) begin
      for (int k = 0; k < 3; k++) begin
        tests++;
        if (q[k].size() != 0) begin
          fails++;
          $display("FAIL drain_ch%0d: %0d left, required 0", k, q[k].size());
        end
      end
      tests++;
      if (lv.size() != 0) begin
        fails++;
        $display("FAIL drain_lv: %0d left, required 0", lv.size());
      end
    end

    if (cyc == T_END + 2) begin
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
    end

    if (cyc == T_RST) begin
      #3;
      tests++;
      if (ce_o !== '0 || ready_o !== 1'b0 || inc_ready !== 1'b0) begin
        fails++;
        $display("FAIL async_reset: ce=%0h rdy=%0b ird=%0b, required 0",
                 ce_o, ready_o, inc_ready);
      end
`ifdef CLKEN_SQUARE_EN
      tests++;
      if (sq_o !== '0) begin
        fails++;
        $display("FAIL async_reset_sq: got %0h want 0", sq_o);
      end
`endif
    end
  end

endmodule
